// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - funct3 encodings for loads and stores
//     - FSM state encoding
//     - byte-enable width
//     - access_fault(): decides whether an access is illegal or misaligned
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned LSU_DW  = 32;
  localparam int unsigned LSU_BEW = LSU_DW / 8;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // An access faults when it is both a load and a store, uses an encoding
  // the memory stage does not implement, or is not naturally aligned.
  function automatic logic access_fault(input logic       ld,
                                        input logic       st,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f;
    f = 1'b0;
    if (ld && st) begin
      f = 1'b1;
    end else if (ld) begin
      case (f3)
        LB, LBU: f = 1'b0;
        LH, LHU: f = off[0];
        LW:      f = |off;
        default: f = 1'b1;
      endcase
    end else if (st) begin
      case (f3)
        SB:      f = 1'b0;
        SH:      f = off[0];
        SW:      f = |off;
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
//   Combinational load-data alignment: picks the byte or halfword lane named
//   by the low address bits and sign- or zero-extends it according to funct3.
//   Ports:
//     rdata_i    raw word returned by memory
//     addr_lo_i  low two bits of the access address
//     funct3_i   load funct3 (LB/LH/LW/LBU/LHU)
//     data_o     aligned, extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [2:0]    funct3_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
  end

  // Halfword accesses are only issued when aligned, so addr[1] alone selects.
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{(DW-8){byte_lane[7]}}, byte_lane};
      LBU:     data_o = {{(DW-8){1'b0}}, byte_lane};
      LH:      data_o = {{(DW-16){half_lane[15]}}, half_lane};
      LHU:     data_o = {{(DW-16){1'b0}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage behind the execute ALU. Accepts one load or store at
//   a time, drives a req/gnt/rvalid data-memory port, and returns an aligned,
//   extended load result with a one-cycle done_o pulse. Illegal or misaligned
//   accesses never reach memory; they complete with fault_o set.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     valid_i         execute-stage instruction valid
//     load_i/store_i  instruction kind
//     funct3_i        access width / signedness
//     addr_i          effective address
//     store_data_i    rs2 value
//     stall_o         holds the upstream pipeline while busy
//     done_o          completion pulse (RESP state)
//     load_data_o     extended load data, valid with done_o
//     fault_o         misaligned/illegal flag, valid with done_o
//     mem_*_o/_i      data-memory request/response port
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      funct3_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   store_data_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [DW-1:0]   load_data_o,
  output logic            fault_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i
);

  lsu_state_e state_q, state_d;

  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [DW/8-1:0] be_q,    be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            fault_q, fault_d;
  logic [DW-1:0]   load_data_q;
  logic [DW-1:0]   aligned_rdata;

  logic start;
  logic capture;

  assign start   = valid_i & (load_i | store_i);
  assign capture = (state_q == IDLE) && start;
  assign fault_d = access_fault(load_i, store_i, funct3_i, addr_i[1:0]);

  // Byte enables and lane-replicated write data. funct3[1:0] encodes the
  // access size for loads and stores alike, so loads get meaningful byte
  // enables too.
  always_comb begin
    be_d    = '1;
    wdata_d = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_i[15:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = store_data_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)        state_d = fault_d ? RESP : REQ;
      REQ:  if (mem_gnt_i)    state_d = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  lsu_load_align #(
    .DW (DW)
  ) u_load_align (
    .rdata_i   (mem_rdata_i),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .data_o    (aligned_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q      <= addr_i;
        we_q        <= store_i;
        funct3_q    <= funct3_i;
        be_q        <= be_d;
        wdata_q     <= wdata_d;
        fault_q     <= fault_d;
        // Stores and faults report zero load data.
        load_data_q <= '0;
      end
      if ((state_q == WAIT) && mem_rvalid_i) begin
        load_data_q <= aligned_rdata;
      end
    end
  end

  // rst_n gates stall_o because start is combinational from the inputs and
  // the pipeline must not be held while the unit is in reset.
  assign stall_o     = rst_n & (capture || (state_q == REQ) || (state_q == WAIT));
  assign done_o      = (state_q == RESP);
  assign fault_o     = fault_q;
  assign load_data_o = load_data_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[AW-1:2], 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute ALU in the 3-stage pipeline.
- Takes the ALU result as the effective address, plus the store operand and the instruction's funct3.
- Drives a req/gnt/rvalid data-memory port with byte enables and returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline while an access is outstanding; flags misaligned or illegal accesses instead of issuing them.

Parameters:
- DW, 32, data width; only 32 is supported (byte-enable width DW/8 = 4).
- AW, 32, address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  execute-stage instruction valid
- load_i  in  1  instruction is a load
- store_i  in  1  instruction is a store
- funct3_i  in  3  instruction funct3
- addr_i  in  AW  effective address (ALU result)
- store_data_i  in  DW  rs2 value
- stall_o  out  1  hold the upstream pipeline
- done_o  out  1  one-cycle completion pulse
- load_data_o  out  DW  extended load result, valid with done_o
- fault_o  out  1  misaligned/illegal access, valid with done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AW  word-aligned address
- mem_be_o  out  DW/8  byte enables
- mem_wdata_o  out  DW  lane-replicated write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DW  read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE; all registered outputs and capture registers = 0. mem_req_o, stall_o and done_o are 0 while rst_n=0. A reset mid-access abandons it immediately; a late rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- start = valid_i & (load_i | store_i), evaluated in IDLE only.
- Fault conditions:
  - load_i & store_i both set;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- IDLE:
  - On start with no fault: capture addr, we, funct3, be, wdata; go to REQ.
  - On start with a fault: latch fault; go to RESP; no memory request is issued.
  - With no start: stay in IDLE.
- REQ:
  - mem_req_o=1; addr/we/be/wdata held stable until grant.
  - On mem_gnt_i: a store goes to RESP; a load goes to WAIT.
  - mem_rvalid_i seen in REQ is ignored.
- WAIT: on mem_rvalid_i, register the extended read data and go to RESP.
- RESP:
  - done_o=1; load_data_o is valid for a load and 0 for a store or fault; fault_o as latched.
  - Always returns to IDLE; no new access is accepted in RESP.
- stall_o = (IDLE & start) | REQ | WAIT. It is 0 in RESP, so the pipeline advances at the end of RESP.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid in the next cycle):
  - load: done_o 3 cycles after start;
  - store: done_o 2 cycles after start;
  - fault: done_o 1 cycle after start.
  - Each extra gnt or rvalid wait cycle adds one cycle.
- Addressing: mem_addr_o = {addr[AW-1:2], 2'b00}.
- Stores:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = halfword replicated ×2.
  - SW: be = 1111; wdata = store_data_i.
- Loads: select the byte or halfword lane by the captured addr[1:0], then:
  - LB/LH sign-extend;
  - LBU/LHU zero-extend;
  - LW passes the word through.
- A store does not wait for rvalid.

Decomposition:
- Package lsu_pkg holds:
  - funct3 encodings as an enum: LB, LH, LW, LBU, LHU; SB, SH, SW;
  - the FSM state enum;
  - the be-width constant DW/8.
- Sub-module lsu_load_align: a purely combinational lane select plus extension. Inputs are rdata, addr[1:0] and funct3; output is the extended word.
- Store lane replication and byte-enable generation stay inline.

Test Plan:
- LW at 0x100, rdata=0xDEADBEEF, zero-wait memory -> mem_addr=0x100, be=1111, we=0; done_o 3 cycles after start; load_data_o=0xDEADBEEF; stall_o high for 3 cycles.
- LB at 0x103 and LBU at 0x103 with rdata=0x80FF1234 -> LB gives 0xFFFFFF80; LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB at 0x201, data=0x000000AB; SH at 0x202, data=0x1234 -> SB: addr 0x200, be=0010, wdata=0xABABABAB. SH: be=1100, wdata=0x12341234. done_o 2 cycles after start.
- LW at 0x102, then SH at 0x103 -> fault_o=1 with done_o 1 cycle after start; mem_req_o never asserted; load_data_o=0.
- LW with gnt delayed 3 cycles and rvalid delayed 2 cycles -> addr/be stable throughout REQ; done_o 8 cycles after start; a spurious rvalid during REQ is ignored.
- rst_n pulled low while in WAIT -> mem_req_o, stall_o and done_o go 0 immediately; rvalid after reset release produces no done_o; the next LW completes normally.
